// File: rtl/envelope_generator.sv
// ADSR envelope generator: per-sample-tick state machine with saturating level steps.
// state | meaning:  IDLE 0 silent | ATK 1 rising | DEC 2 falling to sustain | SUS 3 hold | REL 4 falling to 0
module envelope_generator #(
  parameter bit RETRIGGER = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        SAMPLE_TICK,
  input  logic        KEY,
  input  logic [15:0] ATTACK,
  input  logic [15:0] DECAY,
  input  logic [15:0] RLEASE,
  input  logic [15:0] SUSTAIN,
  output logic [15:0] ENV,
  output logic [2:0]  PHASE,
  output logic        ACTIVE,
  output logic        END_PULSE
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ATK  = 3'd1,
    S_DEC  = 3'd2,
    S_SUS  = 3'd3,
    S_REL  = 3'd4
  } phase_e;

  phase_e      state_q, state_d;
  logic [15:0] env_q, env_d;
  logic        end_pulse_q, end_pulse_d;
  logic        trig_pend_q, trig_pend_d;
  logic        key_q, key_prev_q;

  logic               key_rise;
  logic               trigger;
  logic               key_off;
  logic               state_legal;
  logic [2:0]         state_raw;
  logic [16:0]        atk_sum;
  logic signed [17:0] dec_diff;
  logic signed [17:0] sus_ext;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      env_q       <= 16'h0000;
      end_pulse_q <= 1'b0;
      trig_pend_q <= 1'b0;
      key_q       <= 1'b0;
      key_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      env_q       <= env_d;
      end_pulse_q <= end_pulse_d;
      trig_pend_q <= trig_pend_d;
      key_q       <= KEY;
      key_prev_q  <= key_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    env_d       = env_q;
    end_pulse_d = 1'b0;

    state_raw   = state_q;
    state_legal = (state_raw <= 3'd4);
    key_rise    = key_q & ~key_prev_q;
    // A press that lands on the tick edge itself still counts for that tick.
    trigger     = trig_pend_q | key_rise |
                  (key_q & ((state_q == S_IDLE) | (state_q == S_REL)));
    key_off     = ~key_q & ((state_q == S_ATK) | (state_q == S_DEC) | (state_q == S_SUS));
    trig_pend_d = SAMPLE_TICK ? 1'b0 : (trig_pend_q | key_rise);

    atk_sum  = {1'b0, env_q} + {1'b0, ATTACK};
    dec_diff = $signed({2'b00, env_q}) - $signed({2'b00, DECAY});
    sus_ext  = $signed({2'b00, SUSTAIN});

    if (SAMPLE_TICK) begin
      if (!state_legal) begin
        state_d = S_IDLE;
        env_d   = 16'h0000;
      end else if (trigger) begin
        state_d = S_ATK;
        env_d   = RETRIGGER ? env_q : 16'h0000;
      end else if (key_off) begin
        state_d = S_REL;
      end else begin
        case (state_q)
          S_ATK: begin
            if ((ATTACK == 16'd0) || (atk_sum >= 17'h0FFFF)) begin
              env_d   = 16'hFFFF;
              state_d = S_DEC;
            end else begin
              env_d = atk_sum[15:0];
            end
          end
          S_DEC: begin
            if ((DECAY == 16'd0) || (dec_diff <= sus_ext)) begin
              env_d   = SUSTAIN;
              state_d = S_SUS;
            end else begin
              env_d = dec_diff[15:0];
            end
          end
          S_SUS: env_d = SUSTAIN;
          S_REL: begin
            if ((RLEASE == 16'd0) || (env_q <= RLEASE)) begin
              env_d       = 16'h0000;
              state_d     = S_IDLE;
              end_pulse_d = 1'b1;
            end else begin
              env_d = env_q - RLEASE;
            end
          end
          default: env_d = 16'h0000;
        endcase
      end
    end
  end

  assign ENV       = env_q;
  assign PHASE     = state_q;
  assign ACTIVE    = (state_q != S_IDLE);
  assign END_PULSE = end_pulse_q;

endmodule

// File: tb/tb_envelope_generator.sv
// Scoreboard bench for envelope_generator: driver pushes model expectations per tick,
// an independent monitor pops and compares one cycle after each tick.
module tb_envelope_generator;

  localparam bit RETRIG = 1'b1;
  localparam int P_IDLE = 0, P_ATK = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        SAMPLE_TICK;
  logic        KEY;
  logic [15:0] ATTACK, DECAY, RLEASE, SUSTAIN;
  logic [15:0] ENV;
  logic [2:0]  PHASE;
  logic        ACTIVE;
  logic        END_PULSE;

  envelope_generator #(.RETRIGGER(RETRIG)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SAMPLE_TICK(SAMPLE_TICK), .KEY(KEY),
    .ATTACK(ATTACK), .DECAY(DECAY), .RLEASE(RLEASE), .SUSTAIN(SUSTAIN),
    .ENV(ENV), .PHASE(PHASE), .ACTIVE(ACTIVE), .END_PULSE(END_PULSE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int phase;
    int env;
    int endp;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model: envelope level, phase, "press seen since last tick",
  // and the key level as it stood one and two clocks back
  int m_phase = P_IDLE;
  int m_env   = 0;
  bit m_pend  = 1'b0;
  bit k1 = 1'b0, k2 = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_tick();
    exp_t e;
    int   a, d, s, r;
    bit   held;
    a = int'(ATTACK); d = int'(DECAY); s = int'(SUSTAIN); r = int'(RLEASE);
    held   = k1;
    e.endp = 0;
    if (m_pend || (held && (m_phase == P_IDLE || m_phase == P_REL))) begin
      m_phase = P_ATK;
      if (!RETRIG) m_env = 0;
    end else if (!held && (m_phase == P_ATK || m_phase == P_DEC || m_phase == P_SUS)) begin
      m_phase = P_REL;
    end else begin
      case (m_phase)
        P_ATK: if (a == 0 || m_env + a >= 65535) begin m_env = 65535; m_phase = P_DEC; end
               else m_env = m_env + a;
        P_DEC: if (d == 0 || m_env - d <= s) begin m_env = s; m_phase = P_SUS; end
               else m_env = m_env - d;
        P_SUS: m_env = s;
        P_REL: if (r == 0 || m_env <= r) begin m_env = 0; m_phase = P_IDLE; e.endp = 1; end
               else m_env = m_env - r;
        default: m_env = 0;
      endcase
    end
    m_pend  = 1'b0;
    e.phase = m_phase;
    e.env   = m_env;
    exp_q.push_back(e);
  endfunction

  // called at a falling edge; describes what happens at the next rising edge
  task automatic clk_cycle(input bit key, input bit tick);
    KEY = key;
    SAMPLE_TICK = tick;
    if (!k2 && k1) m_pend = 1'b1;
    if (tick) model_tick();
    k2 = k1;
    k1 = key;
    @(negedge CLK);
  endtask

  task automatic ticks(input int n, input int gap, input bit key);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < gap; c++)
        clk_cycle(key, c == gap - 1);
  endtask

  task automatic set_params(input logic [15:0] a, input logic [15:0] d,
                            input logic [15:0] s, input logic [15:0] r);
    ATTACK = a; DECAY = d; SUSTAIN = s; RLEASE = r;
  endtask

  task automatic mid_reset(input string name);
    SAMPLE_TICK = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    chk({name, "_env"},    int'(ENV), 0);
    chk({name, "_phase"},  int'(PHASE), 0);
    chk({name, "_active"}, int'(ACTIVE), 0);
    chk({name, "_endp"},   int'(END_PULSE), 0);
    m_phase = P_IDLE; m_env = 0; m_pend = 1'b0; k1 = 1'b0; k2 = 1'b0;
    exp_q.delete();
    last_exp.phase = P_IDLE; last_exp.env = 0; last_exp.endp = 0;
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  function automatic logic [15:0] pick_rate();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'($urandom_range(1, 16'h07FF));
      2:       return 16'($urandom_range(16'h0800, 16'h3FFF));
      default: return 16'($urandom_range(16'h4000, 16'hFFFF));
    endcase
  endfunction

  // monitor: the DUT presents a new result the cycle after every tick
  initial begin
    bit   tick_s, rst_s;
    exp_t e;
    last_exp.phase = P_IDLE; last_exp.env = 0; last_exp.endp = 0;
    forever begin
      @(posedge CLK);
      tick_s = SAMPLE_TICK;
      rst_s  = RESET_N;
      #1;
      if (!rst_s || !RESET_N) continue;
      if (tick_s) begin
        if (exp_q.size() == 0) begin
          chk("queue_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          last_exp = e;
          chk("tick_env",    int'(ENV), e.env);
          chk("tick_phase",  int'(PHASE), e.phase);
          chk("tick_endp",   int'(END_PULSE), e.endp);
          chk("tick_active", int'(ACTIVE), int'(e.phase != P_IDLE));
        end
      end else begin
        chk("hold_env",   int'(ENV), last_exp.env);
        chk("hold_phase", int'(PHASE), last_exp.phase);
        chk("hold_endp",  int'(END_PULSE), 0);
      end
    end
  end

  initial begin
    bit key_r;
    int gap;
    RESET_N = 1'b0; SAMPLE_TICK = 1'b0; KEY = 1'b0;
    set_params(16'h4000, 16'h1000, 16'h8000, 16'h2000);
    #1;
    chk("reset_env",    int'(ENV), 0);
    chk("reset_phase",  int'(PHASE), 0);
    chk("reset_active", int'(ACTIVE), 0);
    chk("reset_endp",   int'(END_PULSE), 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;

    // full attack/decay to sustain, then live sustain change, then release
    ticks(13, 4, 1'b1);
    chk("adsr_sus_env",   int'(ENV), 16'h8000);
    chk("adsr_sus_phase", int'(PHASE), P_SUS);
    SUSTAIN = 16'h2000;
    ticks(1, 4, 1'b1);
    chk("sus_track_env", int'(ENV), 16'h2000);
    SUSTAIN = 16'h8000;
    ticks(1, 4, 1'b1);
    ticks(1, 4, 1'b0);
    chk("rel_hold_env",   int'(ENV), 16'h8000);
    chk("rel_hold_phase", int'(PHASE), P_REL);
    ticks(4, 4, 1'b0);
    chk("rel_done_env",   int'(ENV), 0);
    chk("rel_done_phase", int'(PHASE), P_IDLE);

    // zero rates jump straight to the targets
    set_params(16'h0000, 16'h0000, 16'h1234, 16'h0000);
    ticks(2, 3, 1'b1);
    chk("zero_atk_env", int'(ENV), 16'hFFFF);
    ticks(1, 3, 1'b1);
    chk("zero_dec_env", int'(ENV), 16'h1234);
    ticks(2, 3, 1'b0);
    chk("zero_rel_env", int'(ENV), 0);

    // short key pulse between ticks while releasing at 0x3000
    set_params(16'h0000, 16'h0000, 16'h5000, 16'h2000);
    ticks(3, 3, 1'b1);
    ticks(2, 3, 1'b0);
    chk("pulse_pre_env", int'(ENV), 16'h3000);
    clk_cycle(1'b0, 1'b0);
    clk_cycle(1'b1, 1'b0);
    clk_cycle(1'b1, 1'b0);
    clk_cycle(1'b0, 1'b0);
    clk_cycle(1'b0, 1'b1);
    chk("pulse_atk_phase", int'(PHASE), P_ATK);
    chk("pulse_atk_env",   int'(ENV), 16'h3000);
    ticks(1, 3, 1'b0);
    chk("pulse_rel_phase", int'(PHASE), P_REL);
    ticks(3, 2, 1'b0);

    // reset in the middle of decay, key still held
    set_params(16'h0000, 16'h0100, 16'h1000, 16'h0100);
    ticks(4, 2, 1'b1);
    chk("pre_reset_phase", int'(PHASE), P_DEC);
    mid_reset("dec_reset");
    ticks(1, 3, 1'b1);
    chk("post_reset_phase", int'(PHASE), P_ATK);

    // randomized envelopes with consecutive and spaced ticks
    key_r = 1'b1;
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(0, 7) == 0)
        set_params(pick_rate(), pick_rate(), 16'($urandom_range(0, 16'hFFFF)), pick_rate());
      gap = $urandom_range(1, 4);
      for (int c = 0; c < gap; c++) begin
        if ($urandom_range(0, 6) == 0) key_r = ~key_r;
        clk_cycle(key_r, c == gap - 1);
      end
      if ($urandom_range(0, 149) == 0) mid_reset("rand_reset");
    end

    clk_cycle(1'b0, 1'b0);
    clk_cycle(1'b0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/envelope_generator.md
ENVELOPE_GENERATOR -- requirements
Module: envelope_generator

Interface
REQ-001 The block SHALL have parameter RETRIGGER, default 1, meaning 1 = a retrigger starts the attack from the current ENV and 0 = a retrigger forces ENV to 0 first.
REQ-002 The block SHALL have port CLK, input, 1, the single system clock.
REQ-003 The block SHALL have port RESET_N, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port SAMPLE_TICK, input, 1, a one-CLK strobe per audio sample.
REQ-005 The block SHALL have port KEY, input, 1, the gate level from the control register (1 = note held).
REQ-006 The block SHALL have ports ATTACK, DECAY and RLEASE, input, 16 each, unsigned per-tick step sizes.
REQ-007 The block SHALL have port SUSTAIN, input, 16, the unsigned sustain level.
REQ-008 The block SHALL have port ENV, output, 16, the registered envelope level (0x0000 to 0xFFFF).
REQ-009 The block SHALL have port PHASE, output, 3, the current state encoding.
REQ-010 The block SHALL have port ACTIVE, output, 1, high when PHASE != IDLE.
REQ-011 The block SHALL have port END_PULSE, output, 1, a one-CLK pulse on the RELEASE->IDLE transition.

Function
REQ-012 The FSM SHALL have states IDLE=0, ATK=1, DEC=2, SUS=3 and REL=4; encodings 5-7 SHALL go to IDLE on the next tick.
REQ-013 KEY SHALL be registered every CLK; a 0->1 edge of the registered KEY SHALL set trig_pend, and trig_pend SHALL be cleared on the next SAMPLE_TICK.
REQ-014 State and ENV SHALL change only on CLK edges where SAMPLE_TICK=1, with the new values visible in the following cycle (1-cycle latency).
REQ-015 Tick priority, highest first: trigger, then key-off, then rate progression.
REQ-016 Trigger: trig_pend=1, or KEY=1 in IDLE/REL -> ATK, with ENV held (RETRIGGER=1) or ENV:=0 (RETRIGGER=0); there SHALL be no level step on that tick.
REQ-017 Key-off: KEY=0 in ATK/DEC/SUS with no trigger -> REL, with ENV held on that tick.
REQ-018 ATK: if ATTACK=0 or ENV+ATTACK >= 0xFFFF (17-bit sum), then ENV:=0xFFFF and go to DEC; otherwise ENV:=ENV+ATTACK.
REQ-019 DEC: if DECAY=0 or ENV-DECAY <= SUSTAIN (signed 18-bit compare), then ENV:=SUSTAIN and go to SUS; otherwise ENV:=ENV-DECAY.
REQ-020 SUS: ENV:=SUSTAIN on every tick, so a live SUSTAIN change is tracked.
REQ-021 REL: if RLEASE=0 or ENV <= RLEASE, then ENV:=0, go to IDLE, and assert END_PULSE for one CLK; otherwise ENV:=ENV-RLEASE.
REQ-022 IDLE without a trigger SHALL hold ENV=0.
REQ-023 ENV SHALL never wrap; all adds and subtracts SHALL saturate at 0x0000 and 0xFFFF.
REQ-024 ATTACK, DECAY, SUSTAIN and RLEASE SHALL be sampled on each tick, so mid-phase changes take effect on the next tick.
REQ-025 A KEY press and release both occurring between two ticks SHALL still produce ATK, followed by REL on the next tick.
REQ-026 A SAMPLE_TICK held high for consecutive cycles SHALL be treated as one tick per cycle.

Reset
REQ-027 RESET_N=0 SHALL asynchronously force PHASE=IDLE, ENV=0, ACTIVE=0, END_PULSE=0, trig_pend=0 and registered KEY=0.
REQ-028 Reset asserted mid-envelope SHALL abort it immediately without generating END_PULSE.
REQ-029 After RESET_N deasserts while KEY=1, the first tick SHALL trigger ATK.

Verification
REQ-030 ATTACK=0x4000, DECAY=0x1000, SUSTAIN=0x8000, RLEASE=0x2000, KEY=1, ticks every 4 CLK -> ENV 0x4000, 0x8000, 0xC000, 0xFFFF(DEC), 0xEFFF, ... , 0x8000(SUS) after 8 DEC ticks.
REQ-031 From SUS at 0x8000, KEY=0 -> REL with ENV held, then 0x6000, 0x4000, 0x2000, 0x0000 -> IDLE, END_PULSE high for exactly 1 CLK.
REQ-032 ATTACK=0, DECAY=0, RLEASE=0, SUSTAIN=0x1234 -> ENV 0xFFFF, then 0x1234; KEY=0 -> held one tick, then 0x0000.
REQ-033 A 2-CLK KEY pulse between ticks with RETRIGGER=1, in REL at ENV=0x3000 -> ATK from 0x3000, then REL on the next tick.
REQ-034 RESET_N pulsed low mid-DEC -> ENV=0 and PHASE=0 in the same cycle without waiting for CLK, and no END_PULSE.
REQ-035 SUSTAIN changed from 0x8000 to 0x2000 during SUS -> ENV=0x2000 on the next tick.
